mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage, directly downstream of the data-memory stage.
- Aligns and extends the raw memory read word for sub-word loads.
- Selects the writeback value (ALU result, load data, or link address), registers it with destination and write enable for the register file, and tracks halt and retired-instruction state for the debug unit.
- The register file and forwarding unit consume all registered outputs.

Parameters:
BITS_SIZE, 32, datapath width
BITS_REGS, 5, register-address width
BITS_COUNT, 32, retired-instruction counter width

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_step  in  1  stage advance enable; pipeline registers update only when 1
i_exmem_valid  in  1  EX/MEM slot holds a real instruction
i_exmem_halt  in  1  instruction is HALT
i_mem_dato  in  BITS_SIZE  raw word read by data memory at word address alu[31:2]
i_exmem_alu  in  BITS_SIZE  ALU result / effective address
i_exmem_pc8  in  BITS_SIZE  link address PC+8
i_exmem_rd  in  BITS_REGS  destination register
i_exmem_reg_write  in  1  instruction writes register file
i_exmem_mem_to_reg  in  2  00 ALU, 01 load, 10 link, 11 ALU
i_ctl_datomem_size  in  2  00 byte, 01 half, 10 word, 11 word
i_ctl_load_unsigned  in  1  1 zero-extend, 0 sign-extend
o_memwb_valid  out  1  registered valid
o_memwb_reg_write  out  1  registered, qualified write enable
o_memwb_rd  out  BITS_REGS  registered destination
o_memwb_wdata  out  BITS_SIZE  registered writeback value
o_halted  out  1  sticky halt flag
o_retired_count  out  BITS_COUNT  retired instructions, saturating

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs 0; counter 0; o_halted 0. Reset mid-operation discards the in-flight slot.
- Latency: one cycle. Inputs sampled on the rising edge with i_step=1 appear on outputs after that edge. With i_step=0, all state holds.
- Little-endian load extraction (combinational, before the register):
  - Byte: lane = alu[1:0], value = i_mem_dato[8*lane +: 8].
  - Half: alu[1]=0 gives [15:0]; alu[1]=1 gives [31:16]. alu[0] is ignored.
  - Word: passes through unchanged.
  - Extension to BITS_SIZE per i_ctl_load_unsigned.
- Writeback mux: selected per mem_to_reg; code 11 is treated as ALU.
- Write enable qualification: o_memwb_reg_write = valid & reg_write & (rd != 0) & !halt & !o_halted.
- HALT capture: when a valid HALT is captured, o_halted sets on that edge and stays set until reset. The HALT slot itself has reg_write 0 and valid 1.
- While o_halted=1: further steps load valid=0, reg_write=0, rd=0, wdata=0; the counter is frozen.
- Counter: increments by 1 on each step edge capturing a valid, non-HALT instruction while not halted. It saturates at all-ones and never wraps.
- Bubble (valid=0): outputs valid=0, reg_write=0; rd and wdata are still captured (don't-care for consumers).

Optional Feature:
- Macro MEMWB_MISALIGN_TRAP_EN.
- When defined:
  - Adds output o_misaligned (1 bit, reset 0, sticky).
  - A valid load (mem_to_reg=01) that is a half with alu[0]=1, or a word with alu[1:0]!=0, sets o_misaligned.
  - That load's reg_write is forced to 0 and it is not counted.
- When undefined: no port; misaligned loads are extracted as specified above and written normally.

Decomposition:
- Package mips_memwb_pkg holds:
  - size codes SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10
  - writeback select codes WB_ALU=2'b00, WB_MEM=2'b01, WB_LINK=2'b10
- Sub-module load_align_ext: purely combinational (dato, addr[1:0], size, unsigned) -> extended value. It is reused by any future forwarding path from MEM.

Test Plan:
- Reset then step with valid, mem_to_reg=00, alu=0x00001234, rd=3 -> next edge: wdata=0x00001234, reg_write=1, rd=3, count=1.
- Byte load, dato=0x80FF7F01, alu[1:0]=3, signed -> wdata=0xFFFFFF80. Same with unsigned -> 0x00000080. alu[1:0]=1, signed -> 0x0000007F.
- Half load, dato=0x8001ABCD, alu=0x...2, signed -> 0xFFFF8001. alu=0x...0, unsigned -> 0x0000ABCD.
- Write with rd=0 -> reg_write=0, valid=1, count increments. i_step=0 for 5 cycles -> all outputs unchanged.
- Valid HALT captured -> o_halted=1, reg_write=0. Next step with valid ALU instruction -> valid=0, count unchanged. Assert i_reset=0 asynchronously between edges -> all outputs 0 immediately.
- With MEMWB_MISALIGN_TRAP_EN defined, word load at alu=0x00000006 -> o_misaligned=1, reg_write=0, count unchanged.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_memwb_pkg : size / writeback-select codes for the MEM/WB stage.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mips_memwb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // Size code 2'b11 behaves as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr[0];
      default:   is_misaligned = (addr != 2'b00);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wb_stage_if : EX/MEM inputs and MEM/WB outputs of mem_wb_stage.      |
// | Optional macro: MEMWB_MISALIGN_TRAP_EN.   Revision: 1.0                  |
// +--------------------------------------------------------------------------+
interface mem_wb_stage_if #(
  parameter int BITS_SIZE  = 32,
  parameter int BITS_REGS  = 5,
  parameter int BITS_COUNT = 32
);
  logic                  i_step;
  logic                  i_exmem_valid;
  logic                  i_exmem_halt;
  logic [BITS_SIZE-1:0]  i_mem_dato;
  logic [BITS_SIZE-1:0]  i_exmem_alu;
  logic [BITS_SIZE-1:0]  i_exmem_pc8;
  logic [BITS_REGS-1:0]  i_exmem_rd;
  logic                  i_exmem_reg_write;
  logic [1:0]            i_exmem_mem_to_reg;
  logic [1:0]            i_ctl_datomem_size;
  logic                  i_ctl_load_unsigned;
  logic                  o_memwb_valid;
  logic                  o_memwb_reg_write;
  logic [BITS_REGS-1:0]  o_memwb_rd;
  logic [BITS_SIZE-1:0]  o_memwb_wdata;
  logic                  o_halted;
  logic [BITS_COUNT-1:0] o_retired_count;
`ifdef MEMWB_MISALIGN_TRAP_EN
  logic                  o_misaligned;
`endif

  modport master (
    output i_step, i_exmem_valid, i_exmem_halt, i_mem_dato, i_exmem_alu, i_exmem_pc8,
           i_exmem_rd, i_exmem_reg_write, i_exmem_mem_to_reg, i_ctl_datomem_size,
           i_ctl_load_unsigned,
`ifdef MEMWB_MISALIGN_TRAP_EN
    input  o_misaligned,
`endif
    input  o_memwb_valid, o_memwb_reg_write, o_memwb_rd, o_memwb_wdata, o_halted,
           o_retired_count
  );

  modport slave (
    input  i_step, i_exmem_valid, i_exmem_halt, i_mem_dato, i_exmem_alu, i_exmem_pc8,
           i_exmem_rd, i_exmem_reg_write, i_exmem_mem_to_reg, i_ctl_datomem_size,
           i_ctl_load_unsigned,
`ifdef MEMWB_MISALIGN_TRAP_EN
    output o_misaligned,
`endif
    output o_memwb_valid, o_memwb_reg_write, o_memwb_rd, o_memwb_wdata, o_halted,
           o_retired_count
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage_load_align_ext.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_align_ext : little-endian sub-word extraction and extension.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_align_ext
  import mips_memwb_pkg::*;
#(
  parameter int BITS_SIZE = 32
) (
  input  logic [BITS_SIZE-1:0] i_dato,
  input  logic [1:0]           i_addr,
  input  logic [1:0]           i_size,
  input  logic                 i_unsigned,
  output logic [BITS_SIZE-1:0] o_value
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = i_dato[{i_addr, 3'b000} +: 8];
    half_lane = i_addr[1] ? i_dato[31:16] : i_dato[15:0];
    case (i_size)
      SIZE_BYTE: o_value = {{(BITS_SIZE-8){~i_unsigned & byte_lane[7]}}, byte_lane};
      SIZE_HALF: o_value = {{(BITS_SIZE-16){~i_unsigned & half_lane[15]}}, half_lane};
      default:   o_value = i_dato;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wb_stage : MEM/WB register with load alignment, halt and retire cnt. |
// | Optional macro: MEMWB_MISALIGN_TRAP_EN.   Revision: 1.0                  |
// +--------------------------------------------------------------------------+
module mem_wb_stage
  import mips_memwb_pkg::*;
#(
  parameter int BITS_SIZE  = 32,
  parameter int BITS_REGS  = 5,
  parameter int BITS_COUNT = 32
) (
  input  logic         i_clk,
  input  logic         i_reset,
  mem_wb_stage_if.slave bus
);

  localparam logic [BITS_COUNT-1:0] CNT_ONE = {{(BITS_COUNT-1){1'b0}}, 1'b1};

  logic [BITS_SIZE-1:0]  load_value;
  logic [BITS_SIZE-1:0]  wb_value;
  logic                  trap;
  logic                  retire;

  logic                  valid_q, valid_d;
  logic                  reg_write_q, reg_write_d;
  logic [BITS_REGS-1:0]  rd_q, rd_d;
  logic [BITS_SIZE-1:0]  wdata_q, wdata_d;
  logic                  halted_q, halted_d;
  logic [BITS_COUNT-1:0] count_q, count_d;
  logic                  misaligned_q, misaligned_d;

  load_align_ext #(.BITS_SIZE(BITS_SIZE)) u_align (
    .i_dato     (bus.i_mem_dato),
    .i_addr     (bus.i_exmem_alu[1:0]),
    .i_size     (bus.i_ctl_datomem_size),
    .i_unsigned (bus.i_ctl_load_unsigned),
    .o_value    (load_value)
  );

  always_comb begin
    case (bus.i_exmem_mem_to_reg)
      WB_MEM:  wb_value = load_value;
      WB_LINK: wb_value = bus.i_exmem_pc8;
      default: wb_value = bus.i_exmem_alu;
    endcase

`ifdef MEMWB_MISALIGN_TRAP_EN
    trap = bus.i_exmem_valid & (bus.i_exmem_mem_to_reg == WB_MEM) &
           is_misaligned(bus.i_ctl_datomem_size, bus.i_exmem_alu[1:0]);
`else
    trap = 1'b0;
`endif

    retire = bus.i_exmem_valid & ~bus.i_exmem_halt & ~halted_q & ~trap;

    // Once halted, every further slot is squashed to an all-zero bubble.
    if (halted_q) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      rd_d        = '0;
      wdata_d     = '0;
    end else begin
      valid_d     = bus.i_exmem_valid;
      reg_write_d = bus.i_exmem_valid & bus.i_exmem_reg_write & (bus.i_exmem_rd != '0) &
                    ~bus.i_exmem_halt & ~trap;
      rd_d        = bus.i_exmem_rd;
      wdata_d     = wb_value;
    end

    halted_d     = halted_q | (bus.i_exmem_valid & bus.i_exmem_halt);
    count_d      = (retire && (count_q != '1)) ? count_q + CNT_ONE : count_q;
    misaligned_d = misaligned_q | (trap & ~halted_q);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      wdata_q      <= '0;
      halted_q     <= 1'b0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else if (bus.i_step) begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      wdata_q      <= wdata_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.o_memwb_valid     = valid_q;
  assign bus.o_memwb_reg_write = reg_write_q;
  assign bus.o_memwb_rd        = rd_q;
  assign bus.o_memwb_wdata     = wdata_q;
  assign bus.o_halted          = halted_q;
  assign bus.o_retired_count   = count_q;
`ifdef MEMWB_MISALIGN_TRAP_EN
  assign bus.o_misaligned      = misaligned_q;
`endif

endmodule
`default_nettype wire
